// File: rtl/and_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : and_gate_pkg
// Description : Shared defaults and sizing helper for the and_gate block.
// Revision    : 1.0
// ============================================================================
package and_gate_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    // Number of bits needed to hold a set-bit count of 0..width.
    function automatic int cnt_w_for(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/and_gate_popcount.sv
`default_nettype none
// ============================================================================
// Module      : and_gate_popcount
// Description : Combinational WIDTH-bit population count.
// Revision    : 1.0
// ============================================================================
module and_gate_popcount
    import and_gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]              bits,
    output logic [cnt_w_for(WIDTH)-1:0]   ones
);

    localparam int ONES_W = cnt_w_for(WIDTH);

    logic [ONES_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum = w_sum + ONES_W'(bits[i]);
        end
    end

    assign ones = w_sum;

endmodule
`default_nettype wire

// File: rtl/and_gate.sv
`default_nettype none
// ============================================================================
// Module      : and_gate
// Description : Bitwise AND with registered result, reduction flags, set-bit
//               count and a saturating capture counter.
// Revision    : 1.0
// ============================================================================
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic [WIDTH-1:0]              c,
    input  logic                          in_valid,
    output logic [WIDTH-1:0]              c_q,
    output logic                          out_valid,
    output logic                          c_all,
    output logic                          c_any,
    output logic [cnt_w_for(WIDTH)-1:0]   c_ones,
    output logic [CNT_W-1:0]              txn_cnt
);

    localparam int               ONES_W    = cnt_w_for(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [WIDTH-1:0]  w_and;
    logic              w_all;
    logic              w_any;
    logic [ONES_W-1:0] w_ones;

    logic [WIDTH-1:0]  r_c_q;
    logic              r_out_valid;
    logic              r_c_all;
    logic              r_c_any;
    logic [ONES_W-1:0] r_c_ones;
    logic [CNT_W-1:0]  r_txn_cnt;

    assign w_and = a & b;
    assign w_all = &w_and;
    assign w_any = |w_and;

    and_gate_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .bits (w_and),
        .ones (w_ones)
    );

    // Flags and count are captured alongside c_q so they always describe it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_q       <= '0;
            r_out_valid <= 1'b0;
            r_c_all     <= 1'b0;
            r_c_any     <= 1'b0;
            r_c_ones    <= '0;
            r_txn_cnt   <= '0;
        end else if (in_valid) begin
            r_c_q       <= w_and;
            r_out_valid <= 1'b1;
            r_c_all     <= w_all;
            r_c_any     <= w_any;
            r_c_ones    <= w_ones;
            if (r_txn_cnt != c_cnt_max) begin
                r_txn_cnt <= r_txn_cnt + 1'b1;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign c         = w_and;
    assign c_q       = r_c_q;
    assign out_valid = r_out_valid;
    assign c_all     = r_c_all;
    assign c_any     = r_c_any;
    assign c_ones    = r_c_ones;
    assign txn_cnt   = r_txn_cnt;

endmodule
`default_nettype wire

// File: tb/tb_and_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_and_gate
// Description : Directed self-checking bench for and_gate (WIDTH=1 and 8).
// Revision    : 1.0
// ============================================================================
module tb_and_gate;

    logic       clk;
    logic       rst;

    logic [7:0] a8, b8, c8, c_q8;
    logic       in_valid8, out_valid8, c_all8, c_any8;
    logic [3:0] c_ones8;
    logic [2:0] txn_cnt8;

    logic       a1, b1, c1, c_q1;
    logic       in_valid1, out_valid1, c_all1, c_any1;
    logic       c_ones1;
    logic [15:0] txn_cnt1;

    int vectors;
    int miscompares;

    and_gate #(.WIDTH(8), .CNT_W(3)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .in_valid(in_valid8),
        .c_q(c_q8), .out_valid(out_valid8), .c_all(c_all8), .c_any(c_any8),
        .c_ones(c_ones8), .txn_cnt(txn_cnt8)
    );

    and_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .in_valid(in_valid1),
        .c_q(c_q1), .out_valid(out_valid1), .c_all(c_all1), .c_any(c_any1),
        .c_ones(c_ones1), .txn_cnt(txn_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        a8 = '0; b8 = '0; in_valid8 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; in_valid1 = 1'b0;

        // Combinational truth table, no clock edge relied upon.
        #1; check("tt_00", c1, 0);
        #4; a1 = 1'b0; b1 = 1'b1; #1; check("tt_01", c1, 0);
        #9; a1 = 1'b1; b1 = 1'b0; #1; check("tt_10", c1, 0);
        #4; a1 = 1'b1; b1 = 1'b1; #1; check("tt_11", c1, 1);

        tick(); tick();
        check("rst_c_q",    c_q8, 0);
        check("rst_ov",     out_valid8, 0);
        check("rst_all",    c_all8, 0);
        check("rst_any",    c_any8, 0);
        check("rst_ones",   c_ones8, 0);
        check("rst_txn",    txn_cnt8, 0);
        check("rst_all_w1", c_all1, 0);
        rst = 1'b0;

        // WIDTH=1 capture of 1&1.
        a1 = 1'b1; b1 = 1'b1; in_valid1 = 1'b1;
        tick(); in_valid1 = 1'b0;
        check("w1_c_q",  c_q1, 1);
        check("w1_all",  c_all1, 1);
        check("w1_any",  c_any1, 1);
        check("w1_ones", c_ones1, 1);
        check("w1_txn",  txn_cnt1, 1);

        // Capture latency.
        a8 = 8'hF0; b8 = 8'h3C; in_valid8 = 1'b1;
        #1; check("comb_c8", c8, 8'h30);
        tick(); in_valid8 = 1'b0;
        check("cap_c_q",  c_q8, 8'h30);
        check("cap_ones", c_ones8, 2);
        check("cap_any",  c_any8, 1);
        check("cap_all",  c_all8, 0);
        check("cap_ov",   out_valid8, 1);
        check("cap_txn",  txn_cnt8, 1);
        tick();
        check("hold_ov",  out_valid8, 0);
        check("hold_c_q", c_q8, 8'h30);

        // All ones.
        a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
        tick(); in_valid8 = 1'b0;
        check("ff_all",  c_all8, 1);
        check("ff_ones", c_ones8, 8);
        check("ff_any",  c_any8, 1);
        check("ff_txn",  txn_cnt8, 2);

        // Disjoint operands give zero.
        a8 = 8'hAA; b8 = 8'h55; in_valid8 = 1'b1;
        tick(); in_valid8 = 1'b0;
        check("zero_c_q",  c_q8, 0);
        check("zero_any",  c_any8, 0);
        check("zero_ones", c_ones8, 0);
        check("zero_all",  c_all8, 0);

        // Reset wins over a simultaneous capture.
        a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1; rst = 1'b1;
        tick();
        check("rp_c_q", c_q8, 0);
        check("rp_all", c_all8, 0);
        check("rp_any", c_any8, 0);
        check("rp_ones", c_ones8, 0);
        check("rp_ov",  out_valid8, 0);
        check("rp_txn", txn_cnt8, 0);
        rst = 1'b0;

        // Back-to-back captures; counter saturates at 7.
        for (int i = 0; i < 10; i++) begin
            a8 = 8'(i + 1); b8 = 8'h0F;
            tick();
            check("b2b_ov",  out_valid8, 1);
            check("b2b_c_q", c_q8, (i + 1) & 8'h0F);
            check("sat_txn", txn_cnt8, (i + 1 < 7) ? (i + 1) : 7);
        end
        in_valid8 = 1'b0;
        rst = 1'b1;
        tick();
        check("sat_rst_txn", txn_cnt8, 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
